// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and helpers for the multi-port register file.
//   - state_t    : initialisation sequencer states (ST_INIT, ST_RUN)
//   - init_value : power-up image of a register, masked to the data width
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of the value returned by init_value; callers cast down to WIDTH.
    localparam int INIT_VAL_W = 64;

    // Register i powers up holding i; register 0 always holds 0.
    function automatic logic [INIT_VAL_W-1:0] init_value(input int unsigned index,
                                                         input int unsigned width);
        logic [INIT_VAL_W-1:0] mask;
        logic [INIT_VAL_W-1:0] val;
        if (width >= INIT_VAL_W) begin
            mask = '1;
        end else begin
            mask = (64'(1) << width) - 64'(1);
        end
        val = (index == 0) ? '0 : 64'(index);
        return val & mask;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// -----------------------------------------------------------------------------
// regfile_init_seq
//   Post-reset initialisation sweep. After reset is released it walks idx from
//   0 to DEPTH-1, one register per clock, asking the array to load the
//   power-up image. The final write moves the FSM to RUN and raises ready.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (restarts the sweep)
//   init_we    out  array write request from the sweep
//   init_addr  out  register being initialised
//   init_data  out  value to load into init_addr
//   ready      out  high once the sweep has completed
// -----------------------------------------------------------------------------
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_we,
    output logic [AW-1:0]    init_addr,
    output logic [WIDTH-1:0] init_data,
    output logic             ready
);

    state_t        state, state_nx;
    logic [AW-1:0] idx,   idx_nx;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (state == ST_INIT) begin
            idx_nx = idx + 1'b1;
            if (idx == AW'(DEPTH - 1)) begin
                state_nx = ST_RUN;
            end
        end
    end

    // Outputs. ready is a decode of the registered state, so it rises on the
    // same edge that performs the last sweep write.
    always_comb begin
        init_we   = (state == ST_INIT);
        ready     = (state == ST_RUN);
        init_addr = idx;
        init_data = WIDTH'(init_value(32'(idx), 32'(WIDTH)));
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-read-port register file with one clocked write port,
//   a post-reset initialisation sweep, write-to-read bypass and an optional
//   hard-wired zero register.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   rd_addr  in   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data  out  NRD packed read data,      port k at [k*WIDTH +: WIDTH]
//   wr_en    in   write enable
//   wr_addr  in   write register number
//   wr_data  in   write data
//   ready    out  high once initialisation is complete
//   wr_drop  out  registered pulse: a requested write was discarded
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NRD       = 2,
    parameter int ZERO_REG0 = 0,
    parameter int BYPASS    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_data,
    input  logic                   wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   ready,
    output logic                   wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic [WIDTH-1:0] init_data;

    logic             zero_hit;
    logic             wr_accept;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    regfile_init_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .ready     (ready)
    );

    // A user write is taken only in RUN, outside reset, and never to a
    // hard-wired zero register.
    assign zero_hit  = (ZERO_REG0 != 0) && (wr_addr == '0);
    assign wr_accept = !reset && ready && wr_en && !zero_hit;

    // The sweep owns the write port until ready; afterwards the user does.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!reset && init_we) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = init_data;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the array has no reset term; the sweep reloads it after reset, and
    // leaving it out keeps it mappable to plain RAM/latch-array cells.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (!ready || zero_hit);
        end
    end

    // Combinational read ports. Before ready the array may hold stale or
    // unknown data, so reads are forced to zero.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    addr_k;
        logic [WIDTH-1:0] data_k;

        assign addr_k = rd_addr[k*AW +: AW];

        always_comb begin
            if (!ready) begin
                data_k = '0;
            end else if ((ZERO_REG0 != 0) && (addr_k == '0)) begin
                data_k = '0;
            end else if ((BYPASS != 0) && wr_accept && (wr_addr == addr_k)) begin
                data_k = wr_data;
            end else begin
                data_k = mem[addr_k];
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = data_k;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Three 8x8, 2-read-port instances share one
//   stimulus bus (a: bypass on, b: bypass off, c: zero register), and a
//   16-bit, 32-deep, 4-read-port instance has its own bus.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_data_a, rd_data_b, rd_data_c;
    logic        ready_a, ready_b, ready_c;
    logic        wr_drop_a, wr_drop_b, wr_drop_c;

    logic [19:0] rd_addr_d;
    logic [63:0] rd_data_d;
    logic        wr_en_d;
    logic [4:0]  wr_addr_d;
    logic [15:0] wr_data_d;
    logic        ready_d, wr_drop_d;

    int tests = 0;
    int fails = 0;

    regfile_mp #(.WIDTH(8), .DEPTH(8), .NRD(2), .ZERO_REG0(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_a), .wr_drop(wr_drop_a));

    regfile_mp #(.WIDTH(8), .DEPTH(8), .NRD(2), .ZERO_REG0(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_b), .wr_drop(wr_drop_b));

    regfile_mp #(.WIDTH(8), .DEPTH(8), .NRD(2), .ZERO_REG0(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_c), .wr_drop(wr_drop_c));

    regfile_mp #(.WIDTH(16), .DEPTH(32), .NRD(4), .ZERO_REG0(0), .BYPASS(1)) dut_d (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
        .wr_en(wr_en_d), .wr_addr(wr_addr_d), .wr_data(wr_data_d),
        .ready(ready_d), .wr_drop(wr_drop_d));

    // Advance one clock edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rd_addr = {3'd5, 3'd3};
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({ready_a, ready_b, ready_c, wr_drop_a, wr_drop_b, wr_drop_c} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {ready_a, ready_b, ready_c, wr_drop_a, wr_drop_b, wr_drop_c});
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests++;
            if ({ready_a, ready_b, ready_c} !== ((e == 8) ? 3'b111 : 3'b000)) begin
                fails++;
                $display("FAIL sweep_ready edge %0d: got %b expected %b", e,
                         {ready_a, ready_b, ready_c}, (e == 8) ? 3'b111 : 3'b000);
            end
        end
        #1;
        tests++;
        if (rd_data_a !== 16'h0503) begin
            fails++;
            $display("FAIL init_image: got %h expected 0503", rd_data_a);
        end
    endtask

    task automatic test_bypass();
        rd_addr = {3'd4, 3'd4};
        wr_en   = 1'b1;
        wr_addr = 3'd4;
        wr_data = 8'hA5;
        #1;
        tests++;
        if (rd_data_a !== 16'hA5A5) begin
            fails++;
            $display("FAIL bypass_on_same_cycle: got %h expected a5a5", rd_data_a);
        end
        tests++;
        if (rd_data_b !== 16'h0404) begin
            fails++;
            $display("FAIL bypass_off_same_cycle: got %h expected 0404", rd_data_b);
        end
        tick();
        wr_en = 1'b0;
        #1;
        tests++;
        if (rd_data_b !== 16'hA5A5) begin
            fails++;
            $display("FAIL bypass_off_next_cycle: got %h expected a5a5", rd_data_b);
        end
        tests++;
        if ({wr_drop_a, wr_drop_b, wr_drop_c} !== 3'b000) begin
            fails++;
            $display("FAIL run_write_no_drop: got %b expected 000",
                     {wr_drop_a, wr_drop_b, wr_drop_c});
        end
    endtask

    task automatic test_zero_reg();
        rd_addr = {3'd0, 3'd0};
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'hFF;
        #1;
        tests++;
        if (rd_data_c !== 16'h0000) begin
            fails++;
            $display("FAIL zero_reg_write_cycle: got %h expected 0000", rd_data_c);
        end
        tests++;
        if (rd_data_a !== 16'hFFFF) begin
            fails++;
            $display("FAIL reg0_bypass_when_not_zero: got %h expected ffff", rd_data_a);
        end
        tick();
        wr_en = 1'b0;
        #1;
        tests++;
        if ({wr_drop_c, wr_drop_a} !== 2'b10) begin
            fails++;
            $display("FAIL zero_reg_drop: got %b expected 10", {wr_drop_c, wr_drop_a});
        end
        tests++;
        if ({rd_data_c, rd_data_a} !== 32'h0000_FFFF) begin
            fails++;
            $display("FAIL zero_reg_next_cycle: got %h expected 0000ffff",
                     {rd_data_c, rd_data_a});
        end
        tick();
        tests++;
        if (wr_drop_c !== 1'b0) begin
            fails++;
            $display("FAIL zero_reg_drop_pulse: got %b expected 0", wr_drop_c);
        end
    endtask

    task automatic test_drop_in_sweep();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        rd_addr = {3'd0, 3'd2};
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h99;
        #1;
        tests++;
        if (rd_data_a !== 16'h0000) begin
            fails++;
            $display("FAIL sweep_read_zero: got %h expected 0000", rd_data_a);
        end
        tick();
        wr_en = 1'b0;
        tests++;
        if ({wr_drop_a, wr_drop_b, wr_drop_c} !== 3'b111) begin
            fails++;
            $display("FAIL sweep_drop: got %b expected 111",
                     {wr_drop_a, wr_drop_b, wr_drop_c});
        end
        tick();
        tests++;
        if ({wr_drop_a, wr_drop_b, wr_drop_c} !== 3'b000) begin
            fails++;
            $display("FAIL sweep_drop_pulse: got %b expected 000",
                     {wr_drop_a, wr_drop_b, wr_drop_c});
        end
        repeat (4) tick();
        #1;
        tests++;
        if ({ready_a, rd_data_a, rd_data_c} !== {1'b1, 16'h0002, 16'h0002}) begin
            fails++;
            $display("FAIL sweep_write_ignored: got %b %h %h expected 1 0002 0002",
                     ready_a, rd_data_a, rd_data_c);
        end
    endtask

    task automatic test_reset_mid_run();
        rd_addr = {3'd6, 3'd6};
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        #1;
        tests++;
        if (rd_data_a !== 16'hEEEE) begin
            fails++;
            $display("FAIL run_write_reg6: got %h expected eeee", rd_data_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({ready_a, rd_data_a} !== 17'h0) begin
            fails++;
            $display("FAIL reset_drops_ready: got %b %h expected 0 0000", ready_a, rd_data_a);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests++;
            if ({ready_a, rd_data_a} !== ((e == 8) ? {1'b1, 16'h0606} : 17'h0)) begin
                fails++;
                $display("FAIL resweep edge %0d: got %b %h", e, ready_a, rd_data_a);
            end
        end
    endtask

    task automatic test_wide();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (!ready_d && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL wide_sweep_length: got %0d edges expected 32", n);
        end
        rd_addr_d = {4{5'd31}};
        #1;
        tests++;
        if (rd_data_d !== {4{16'h001F}}) begin
            fails++;
            $display("FAIL wide_reg31_all_ports: got %h expected 001f001f001f001f", rd_data_d);
        end
        for (int i = 0; i < 32; i++) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 5'(i);
            wr_data_d = 16'hA500 | 16'(i);
            rd_addr_d = {4{5'(i)}};
            #1;
            tests++;
            if (rd_data_d !== {4{16'hA500 | 16'(i)}}) begin
                fails++;
                $display("FAIL wide_bypass reg %0d: got %h", i, rd_data_d);
            end
            tick();
        end
        wr_en_d = 1'b0;
        for (int p = 0; p < 8; p++) begin
            rd_addr_d = {5'(4*p+3), 5'(4*p+2), 5'(4*p+1), 5'(4*p)};
            #1;
            tests++;
            if (rd_data_d !== {16'hA500 | 16'(4*p+3), 16'hA500 | 16'(4*p+2),
                               16'hA500 | 16'(4*p+1), 16'hA500 | 16'(4*p)}) begin
                fails++;
                $display("FAIL wide_readback regs %0d..%0d: got %h", 4*p, 4*p+3, rd_data_d);
            end
        end
        tests++;
        if (wr_drop_d !== 1'b0) begin
            fails++;
            $display("FAIL wide_no_drop: got %b expected 0", wr_drop_d);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        test_reset();
        test_bypass();
        test_zero_reg();
        test_drop_in_sweep();
        test_reset_mid_run();
        test_wide();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
